// File: rtl/aes_inv_sub_bytes_seq.sv
// Sequential InvSubBytes engine: substitutes NUM_LANES 32-bit words of a 128-bit state per cycle.
// Optional macro AES_INV_SUB_FWD_EN adds fwd_i, selecting the forward S-box for a block.
module aes_inv_sub_bytes_seq #(
   parameter int NUM_LANES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
`ifdef AES_INV_SUB_FWD_EN
   input  logic         fwd_i,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4) begin : g_bad_lanes
      $error("aes_inv_sub_bytes_seq: NUM_LANES must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t         fsm, fsm_nxt;
   logic [127:0] state_reg, state_reg_nxt;
   logic [1:0]   cnt, cnt_nxt;
   logic         fwd_q, fwd_nxt;
   logic         last_slice;

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq, acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
   endfunction

`ifdef AES_INV_SUB_FWD_EN
   function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
      logic [7:0] y;
      y = gf_inv(x);
      return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
   endfunction
`endif

   logic [1:0]  lane_idx [NUM_LANES];
   logic [31:0] lane_in  [NUM_LANES];
   logic [31:0] lane_out [NUM_LANES];

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      assign lane_idx[l] = cnt + 2'(l);
      assign lane_in[l]  = state_reg[{lane_idx[l], 5'b0} +: 32];
      for (genvar b = 0; b < 4; b++) begin : g_byte
`ifdef AES_INV_SUB_FWD_EN
         assign lane_out[l][8*b +: 8] = fwd_q ? fwd_sbox(lane_in[l][8*b +: 8])
                                              : inv_sbox(lane_in[l][8*b +: 8]);
`else
         assign lane_out[l][8*b +: 8] = inv_sbox(lane_in[l][8*b +: 8]);
`endif
      end
   end

   // The slice ending at word 3 is the final one of the block.
   assign last_slice = (cnt == 2'(4 - NUM_LANES));
   assign out_state  = state_reg;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      fsm_nxt       = fsm;
      state_reg_nxt = state_reg;
      cnt_nxt       = cnt;
      fwd_nxt       = fwd_q;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      busy          = 1'b0;
      case (fsm)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_reg_nxt = in_state;
               cnt_nxt       = 2'd0;
`ifdef AES_INV_SUB_FWD_EN
               fwd_nxt       = fwd_i;
`endif
               fsm_nxt       = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            for (int l = 0; l < NUM_LANES; l++) begin
               state_reg_nxt[{lane_idx[l], 5'b0} +: 32] = lane_out[l];
            end
            cnt_nxt = cnt + 2'(NUM_LANES);
            if (last_slice) fsm_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) fsm_nxt = IDLE;
         end
         default: fsm_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         state_reg <= '0;
         cnt       <= 2'd0;
         fwd_q     <= 1'b0;
      end else begin
         fsm       <= fsm_nxt;
         state_reg <= state_reg_nxt;
         cnt       <= cnt_nxt;
         fwd_q     <= fwd_nxt;
      end
   end

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Self-checking bench: three engines (NUM_LANES 1, 2, 4) against a table model built from GF(2^8) rules.
// Define AES_INV_SUB_FWD_EN for both RTL and bench to exercise the forward S-box mode.
module tb_aes_inv_sub_bytes_seq;

   localparam logic [127:0] C1_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
   localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
   localparam logic [127:0] R4_IN  = 128'h16ed7c00_16ed7c00_16ed7c00_16ed7c00;
   localparam logic [127:0] R4_OUT = 128'hff530152_ff530152_ff530152_ff530152;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic         busy      [3];
   logic [127:0] in_state  [3];
   logic [127:0] out_state [3];
`ifdef AES_INV_SUB_FWD_EN
   logic         fwd       [3];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_inv_sub_bytes_seq #(.NUM_LANES(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_state  (in_state[g]),
`ifdef AES_INV_SUB_FWD_EN
         .fwd_i     (fwd[g]),
`endif
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_state (out_state[g]),
         .busy      (busy[g])
      );
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference tables derived from the field definition: brute-force inverse, then the affine map.
   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_tables();
      logic [7:0] c, inv, s, x;
      c = 8'h63;
      for (int xi = 0; xi < 256; xi++) begin
         x   = 8'(xi);
         inv = 8'h00;
         for (int yi = 1; yi < 256; yi++) if (gmul(x, 8'(yi)) == 8'h01) inv = 8'(yi);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sb[xi]  = s;
         isb[s]  = x;
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] d, input logic f);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = f ? sb[d[8*i +: 8]] : isb[d[8*i +: 8]];
      return r;
   endfunction

   // Compare process state: one block in flight per engine.
   int           cyc = 0;
   int           stream_k = -1;
   logic         pend     [3];
   logic [127:0] exp_st   [3];
   int           acc_cyc  [3];
   int           prev_acc [3];
   int           accepts  [3];
   int           outs     [3];

   initial begin
      for (int k = 0; k < 3; k++) begin
         pend[k] = 0; exp_st[k] = 0; acc_cyc[k] = 0; prev_acc[k] = -1; accepts[k] = 0; outs[k] = 0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         for (int k = 0; k < 3; k++) begin
            if (stream_k != k) prev_acc[k] = -1;
            if (!rst_n) pend[k] = 0;
            else begin
               if (out_valid[k] && out_ready[k]) begin
                  pend[k] = 0;
                  outs[k]++;
               end
               if (in_valid[k] && in_ready[k]) begin
                  if (prev_acc[k] >= 0) check($sformatf("ii_l%0d", 1 << k), cyc - prev_acc[k], (4 >> k) + 2);
                  prev_acc[k] = cyc;
                  acc_cyc[k]  = cyc;
`ifdef AES_INV_SUB_FWD_EN
                  exp_st[k]   = model(in_state[k], fwd[k]);
`else
                  exp_st[k]   = model(in_state[k], 1'b0);
`endif
                  pend[k]     = 1;
                  accepts[k]++;
               end
            end
         end
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!rst_n) pend[k] = 0;
            check($sformatf("busy_l%0d", 1 << k), busy[k], pend[k]);
            check($sformatf("in_ready_l%0d", 1 << k), in_ready[k], !pend[k]);
            check($sformatf("out_valid_l%0d", 1 << k), out_valid[k],
                  pend[k] && (cyc - acc_cyc[k] >= (4 >> k)));
            if (out_valid[k] && pend[k]) check($sformatf("out_state_l%0d", 1 << k), out_state[k], exp_st[k]);
         end
      end
   end

   task automatic send(input int k, input logic [127:0] d);
      int n = 0;
      while (!in_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
      check("send_ready", in_ready[k], 1'b1);
      in_state[k] = d;
      in_valid[k] = 1'b1;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
   endtask

   task automatic wait_out(input int k, output int n);
      n = 0;
      while (!out_valid[k] && n < 20) begin @(posedge clk); #1; n++; end
      check("out_timeout", out_valid[k], 1'b1);
   endtask

   task automatic pop(input int k);
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int n, a0, o0, rc;
      logic [127:0] da, db;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 0; out_ready[k] = 0; in_state[k] = 0;
`ifdef AES_INV_SUB_FWD_EN
         fwd[k] = 0;
`endif
      end
      build_tables();
      check("model_63",  model({16{8'h63}}, 1'b0), 128'h0);
      check("model_c1",  model(C1_IN, 1'b0), C1_OUT);
      check("model_r4",  model(R4_IN, 1'b0), R4_OUT);
      check("model_fwd", model(128'h0, 1'b1), {16{8'h63}});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_in_ready", in_ready[k], 1'b1);
         check("rst_out_valid", out_valid[k], 1'b0);
         check("rst_busy", busy[k], 1'b0);
         check("rst_out_state", out_state[k], 128'h0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 0x63 everywhere maps to zero; latency and busy window on the single-lane engine
      send(0, {16{8'h63}});
      check("t1_busy_after_accept", busy[0], 1'b1);
      wait_out(0, n);
      check("t1_latency", n, 4);
      check("t1_out", out_state[0], 128'h0);
      pop(0);
      check("t1_busy_after_pop", busy[0], 1'b0);

      // FIPS-197 C.1 vector on every lane count
      for (int k = 0; k < 3; k++) begin
         send(k, C1_IN);
         wait_out(k, n);
         check($sformatf("c1_latency_l%0d", 1 << k), n, 4 >> k);
         check($sformatf("c1_out_l%0d", 1 << k), out_state[k], C1_OUT);
         pop(k);
      end

      // Backpressure in DONE with a competing in_valid
      da = rnd128();
      db = rnd128();
      send(0, da);
      wait_out(0, n);
      a0 = accepts[0];
      in_state[0] = db;
      in_valid[0] = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         check("bp_out_valid", out_valid[0], 1'b1);
         check("bp_in_ready", in_ready[0], 1'b0);
         check("bp_stable", out_state[0], model(da, 1'b0));
      end
      check("bp_no_accept", accepts[0], a0);
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      rc = cyc;
      out_ready[0] = 1'b0;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      check("bp_reaccept", accepts[0], a0 + 1);
      check("bp_reaccept_edge", acc_cyc[0], rc + 1);
      wait_out(0, n);
      check("bp_second", out_state[0], model(db, 1'b0));
      pop(0);

      // Asynchronous reset two cycles into RUN
      send(0, rnd128());
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid[0], 1'b0);
      check("mid_rst_out_state", out_state[0], 128'h0);
      check("mid_rst_busy", busy[0], 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(0, R4_IN);
      wait_out(0, n);
      check("r4_out", out_state[0], R4_OUT);
      pop(0);

`ifdef AES_INV_SUB_FWD_EN
      // Forward mode latched at acceptance; a mid-block change has no effect
      fwd[0] = 1'b1;
      send(0, 128'h0);
      fwd[0] = 1'b0;
      wait_out(0, n);
      check("fwd_out", out_state[0], {16{8'h63}});
      pop(0);
      send(0, 128'h0);
      wait_out(0, n);
      check("inv_after_fwd", out_state[0], {16{8'h52}});
      pop(0);
`endif

      // Back-to-back random stream with both handshakes held high
      for (int k = 0; k < 3; k++) begin
         stream_k = k;
         a0 = accepts[k];
         o0 = outs[k];
         out_ready[k] = 1'b1;
         in_state[k]  = rnd128();
         in_valid[k]  = 1'b1;
         for (int b = 0; b < 8; b++) begin
            n = 0;
            while (accepts[k] != a0 + b + 1 && n < 20) begin @(posedge clk); #1; n++; end
            check("stream_accept", accepts[k], a0 + b + 1);
            in_state[k] = rnd128();
            if (b == 7) in_valid[k] = 1'b0;
         end
         n = 0;
         while (outs[k] != o0 + 8 && n < 20) begin @(posedge clk); #1; n++; end
         check("stream_outputs", outs[k], o0 + 8);
         check("stream_accepts", accepts[k], a0 + 8);
         out_ready[k] = 1'b0;
         stream_k = -1;
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
